// File: rtl/cache_access_arbiter.sv
// Round-robin arbiter sharing one cache among NUM_REQ requesters, with miss-penalty stall.
// Define CACHE_ARB_STATS_EN to build the per-requester hit/miss counters.
module cache_access_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int MISS_PENALTY = 10,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          resp_hit,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic                          cache_en,
  input  logic                          cache_hit,
  input  logic                          cache_miss,
  output logic                          busy,
  output logic                          proto_err,
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  output logic [CNT_WIDTH-1:0]          stat_hits,
  output logic [CNT_WIDTH-1:0]          stat_misses
);

  // state  | meaning
  // IDLE   | arbitrating, req_ready to the round-robin winner
  // ISSUE  | cache_en strobe for the latched address
  // LOOKUP | sample cache_hit/cache_miss
  // STALL  | miss penalty countdown
  // RESP   | resp_valid pulse to owner, statistics update
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);
  localparam logic [SEL_W-1:0] ONE_IDX  = SEL_W'(1);
  localparam logic [7:0]       PEN_LOAD = (MISS_PENALTY == 0) ? 8'd0 : 8'(MISS_PENALTY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOOKUP, S_STALL, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, owner_q, grant_idx, cand;
  logic             grant_found;
  logic [7:0]       stall_cnt_q;
  logic             hit_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_found) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_LOOKUP;
      S_LOOKUP: state_d = (cache_hit || MISS_PENALTY == 0) ? S_RESP : S_STALL;
      S_STALL:  if (stall_cnt_q == 8'd0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_hit   = 1'b0;
    cache_en   = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (grant_found) req_ready[grant_idx] = 1'b1;
      S_ISSUE: cache_en = 1'b1;
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        resp_hit            = hit_q;
      end
      default: ;
    endcase
  end

  // cache_hit wins when both are high; neither high counts as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      cache_addr  <= '0;
      stall_cnt_q <= '0;
      hit_q       <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (grant_found) begin
          owner_q    <= grant_idx;
          cache_addr <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          ptr_q      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ONE_IDX;
        end
        S_LOOKUP: begin
          hit_q       <= cache_hit;
          stall_cnt_q <= PEN_LOAD;
          if (cache_hit == cache_miss) proto_err <= 1'b1;
        end
        S_STALL: if (stall_cnt_q != 8'd0) stall_cnt_q <= stall_cnt_q - 8'd1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q  [NUM_REQ];
  logic [CNT_WIDTH-1:0] miss_cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_cnt_q[i]  <= '0;
        miss_cnt_q[i] <= '0;
      end
    end else if (state_q == S_RESP) begin
      if (hit_q) begin
        if (hit_cnt_q[owner_q] != '1) hit_cnt_q[owner_q] <= hit_cnt_q[owner_q] + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_q[owner_q] != '1) miss_cnt_q[owner_q] <= miss_cnt_q[owner_q] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    stat_hits   = '0;
    stat_misses = '0;
    if (int'(stat_sel) < NUM_REQ) begin
      stat_hits   = hit_cnt_q[stat_sel];
      stat_misses = miss_cnt_q[stat_sel];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_hits       = '0;
  assign stat_misses     = '0;
`endif

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Bench for cache_access_arbiter: directed and random accesses checked against a
// transaction-level round-robin/latency model, with a behavioural cache responder.
module tb_cache_access_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int PEN = 10;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready, resp_valid;
  logic              resp_hit, cache_en, busy, proto_err;
  logic [AW-1:0]     cache_addr;
  logic              cache_hit = 1'b0, cache_miss = 1'b0;
  logic [1:0]        stat_sel;
  logic [CW-1:0]     stat_hits, stat_misses;
  logic [AW-1:0]     addr_arr [NR];

  int n_checks = 0, n_errors = 0, cyc = 0;
  int cache_mode = 0;   // 0 hit, 1 miss, 2 neither, 3 both
  int m_ptr = 0;
  int m_hits [NR];
  int m_misses [NR];
  bit m_proto = 1'b0;

  cache_access_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .MISS_PENALTY(PEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .cache_addr(cache_addr), .cache_en(cache_en),
    .cache_hit(cache_hit), .cache_miss(cache_miss), .busy(busy), .proto_err(proto_err),
    .stat_sel(stat_sel), .stat_hits(stat_hits), .stat_misses(stat_misses));

  for (genvar g = 0; g < NR; g++) begin : g_addr
    assign req_addr[g*AW +: AW] = addr_arr[g];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered cache responder: answers the cycle after the strobe.
  always @(posedge clk) begin
    if (cache_en) begin
      cache_hit  <= (cache_mode == 0) || (cache_mode == 3);
      cache_miss <= (cache_mode == 1) || (cache_mode == 3);
    end else begin
      cache_hit  <= 1'b0;
      cache_miss <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++)
      if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic int first_set(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_proto = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_hits[i]   = 0;
      m_misses[i] = 0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_stats(input string tag);
    int eh, em;
    @(posedge clk); #1;
    for (int s = 0; s < NR; s++) begin
      stat_sel = 2'(s);
      #1;
`ifdef CACHE_ARB_STATS_EN
      eh = m_hits[s]; em = m_misses[s];
`else
      eh = 0; em = 0;
`endif
      check({tag, " stat_hits"}, 64'(stat_hits), 64'(eh));
      check({tag, " stat_misses"}, 64'(stat_misses), 64'(em));
    end
  endtask

  // Drives one transfer and checks every cycle up to and including the response.
  task automatic do_access(input logic [NR-1:0] mask, input int mode, input string tag,
                           output int gidx, output int gcyc);
    int w, lat;
    bit exp_hit;
    logic [NR-1:0] oh;
    w       = rr_winner(mask);
    exp_hit = (mode == 0) || (mode == 3);
    lat     = exp_hit ? 3 : 3 + PEN;
    oh      = NR'(1) << w;
    @(posedge clk); #2;
    req_valid = mask; cache_mode = mode;
    #2;
    gcyc = cyc;
    gidx = first_set(req_ready);
    check({tag, " grant"}, 64'(req_ready), 64'(oh));
    check({tag, " idle busy"}, 64'(busy), 64'(0));
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #4;
      check({tag, " cache_en"}, 64'(cache_en), 64'(c == 1));
      if (c == 1) check({tag, " cache_addr"}, 64'(cache_addr), 64'(addr_arr[w]));
      check({tag, " busy"}, 64'(busy), 64'(1));
      check({tag, " no ready"}, 64'(req_ready), 64'(0));
      if (c < lat) check({tag, " early resp"}, 64'(resp_valid), 64'(0));
    end
    if (mode >= 2) m_proto = 1'b1;
    check({tag, " resp_valid"}, 64'(resp_valid), 64'(oh));
    check({tag, " resp_hit"}, 64'(resp_hit), 64'(exp_hit));
    check({tag, " proto_err"}, 64'(proto_err), 64'(m_proto));
    req_valid = '0;
    m_ptr = (w + 1) % NR;
    if (exp_hit) m_hits[w]++; else m_misses[w]++;
  endtask

  initial begin
    int gi, gc, prev_gc;
    int rr_order [5];
    logic [NR-1:0] m;
    rr_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; stat_sel = '0;
    for (int i = 0; i < NR; i++) addr_arr[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #2;
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst resp_valid", 64'(resp_valid), 64'(0));
    check("rst resp_hit", 64'(resp_hit), 64'(0));
    check("rst cache_en", 64'(cache_en), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst proto_err", 64'(proto_err), 64'(0));
    check("rst cache_addr", 64'(cache_addr), 64'(0));
    check_stats("rst");

    addr_arr[0] = 32'h0000_1000;
    do_access(4'b0001, 0, "single_hit", gi, gc);
    addr_arr[0] = 32'h0000_2040;
    do_access(4'b0001, 1, "miss_pen", gi, gc);
    @(posedge clk); #4;
    check("after miss busy", 64'(busy), 64'(0));
    check("cache_addr hold", 64'(cache_addr), 64'(32'h0000_2040));

    // Reset while the miss penalty is counting down.
    addr_arr[1] = 32'hDEAD_BEE0;
    @(posedge clk); #2;
    req_valid = 4'b0010; cache_mode = 1;
    #2 check("stall grant", 64'(req_ready), 64'(4'b0010));
    repeat (5) @(posedge clk);
    #2 rst = 1'b1; req_valid = '0;
    @(posedge clk); #4;
    check("rst busy next", 64'(busy), 64'(0));
    check("rst no resp", 64'(resp_valid), 64'(0));
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    for (int c = 0; c < PEN + 3; c++) begin
      @(posedge clk); #4;
      check("post rst resp", 64'(resp_valid), 64'(0));
      check("post rst busy", 64'(busy), 64'(0));
    end
    check("post rst cache_addr", 64'(cache_addr), 64'(0));

    for (int i = 0; i < NR; i++) addr_arr[i] = 32'h0000_0100 * (i + 1);
    prev_gc = 0;
    for (int i = 0; i < 5; i++) begin
      do_access(4'b1111, 0, "rr", gi, gc);
      check("rr order", 64'(gi), 64'(rr_order[i]));
      if (i > 0) check("rr spacing", 64'(gc - prev_gc), 64'(4));
      prev_gc = gc;
    end
    check_stats("rr");

    apply_reset();
    addr_arr[2] = 32'h0000_3000;
    do_access(4'b0100, 0, "st0", gi, gc);
    do_access(4'b0100, 1, "st1", gi, gc);
    do_access(4'b0100, 0, "st2", gi, gc);
    do_access(4'b0100, 1, "st3", gi, gc);
    do_access(4'b0100, 0, "st4", gi, gc);
    @(posedge clk); #2;
    stat_sel = 2'd2; #1;
`ifdef CACHE_ARB_STATS_EN
    check("stats r2 hits", 64'(stat_hits), 64'(3));
    check("stats r2 misses", 64'(stat_misses), 64'(2));
`else
    check("stats r2 hits", 64'(stat_hits), 64'(0));
    check("stats r2 misses", 64'(stat_misses), 64'(0));
`endif
    stat_sel = 2'd1; #1;
    check("stats r1 hits", 64'(stat_hits), 64'(0));
    check("stats r1 misses", 64'(stat_misses), 64'(0));

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NR; i++) addr_arr[i] = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        m = NR'($urandom_range(1, (1 << NR) - 1));
        @(posedge clk); #2;
        req_valid = m; #1;
        check("withdraw ready", 64'(req_ready), 64'(NR'(1) << rr_winner(m)));
        req_valid = '0;
        @(posedge clk); #4;
        check("withdraw busy", 64'(busy), 64'(0));
      end
      m = NR'($urandom_range(1, (1 << NR) - 1));
      do_access(m, int'($urandom_range(0, 1)), "rand", gi, gc);
    end
    check_stats("rand");

    addr_arr[3] = 32'hCAFE_0000;
    do_access(4'b1000, 2, "proto none", gi, gc);
    do_access(4'b1000, 0, "proto sticky", gi, gc);
    do_access(4'b1000, 3, "proto both", gi, gc);
    @(posedge clk); #4;
    check("proto held", 64'(proto_err), 64'(1));
    check_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
